// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing arbiter.
//   alu_req_t  : one packed ALU operation (operands plus decode fields)
//   OPC_OP     : register-register ALU opcode
//   OPC_OP_IMM : register-immediate ALU opcode
package alu_pkg;

  typedef struct packed {
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic [19:0] u_imm20;
    logic [4:0]  rs2;
    logic [11:0] imm12;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct1;
  } alu_req_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter holding the single priority flop.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   eligible_i    : per-port eligibility
//   grant_o       : one-hot or zero grant
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] eligible_i,
  output logic [1:0] grant_o
);

  // prio_q names the port favoured when both are eligible.
  logic prio_q, prio_d;

  always_comb begin
    grant_o = eligible_i;
    if (eligible_i == 2'b11) begin
      grant_o = prio_q ? 2'b10 : 2'b01;
    end
    // After a grant the other port becomes favoured; idle cycles keep the pointer.
    prio_d = prio_q;
    if (grant_o[0]) begin
      prio_d = 1'b1;
    end else if (grant_o[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external ALU between two requesters. At most one operation is
// accepted per cycle (round-robin); the ALU result is captured into a
// one-entry response slot for the granted port and returned with its tag.
//   CLK, RST_N              : clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY     : per-port request handshake
//   REQ0/1_OP, REQ0/1_TAG   : per-port operation and tag
//   RSP_VALID/RSP_READY     : per-port response handshake
//   RSP0/1_DATA, RSP0/1_TAG : held result and tag
//   ALU_*                   : operand/decode drive to the shared ALU, ALU_OUT back
//   OP_COUNT                : accepted-operation counter (wraps)
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [1:0]           REQ_VALID,
  output logic [1:0]           REQ_READY,
  input  alu_req_t             REQ0_OP,
  input  alu_req_t             REQ1_OP,
  input  logic [TAG_W-1:0]     REQ0_TAG,
  input  logic [TAG_W-1:0]     REQ1_TAG,
  output logic [1:0]           RSP_VALID,
  input  logic [1:0]           RSP_READY,
  output logic [31:0]          RSP0_DATA,
  output logic [31:0]          RSP1_DATA,
  output logic [TAG_W-1:0]     RSP0_TAG,
  output logic [TAG_W-1:0]     RSP1_TAG,
  output logic [31:0]          ALU_RS1_DATA,
  output logic [31:0]          ALU_RS2_DATA,
  output logic [31:0]          ALU_PC,
  output logic [19:0]          ALU_U_IMM20,
  output logic [11:0]          ALU_IMM12,
  output logic [6:0]           ALU_OPCODE,
  output logic [4:0]           ALU_RS2,
  output logic [2:0]           ALU_FUNCT3,
  output logic [0:0]           ALU_FUNCT1,
  input  logic [31:0]          ALU_OUT,
  output logic [31:0]          OP_COUNT
);

  logic [1:0]       eligible;
  logic [1:0]       grant;
  alu_req_t         sel_op;
  logic [TAG_W-1:0] req_tag [2];

  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q [2];
  logic [31:0]      rsp_data_d [2];
  logic [TAG_W-1:0] rsp_tag_q [2];
  logic [TAG_W-1:0] rsp_tag_d [2];
  logic [31:0]      op_count_q, op_count_d;

  assign req_tag[0] = REQ0_TAG;
  assign req_tag[1] = REQ1_TAG;

  // A full slot that drains this cycle can be refilled in the same cycle.
  // Gating with RST_N keeps REQ_READY low throughout reset.
  assign eligible = REQ_VALID & (~rsp_valid_q | RSP_READY) & {2{RST_N}};

  rr_arb2 u_rr_arb2 (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .eligible_i (eligible),
    .grant_o    (grant)
  );

  assign REQ_READY = grant;

  // Port 0 drives the ALU whenever port 1 is not granted (result ignored if idle).
  assign sel_op       = grant[1] ? REQ1_OP : REQ0_OP;
  assign ALU_RS1_DATA = sel_op.rs1_data;
  assign ALU_RS2_DATA = sel_op.rs2_data;
  assign ALU_PC       = sel_op.pc;
  assign ALU_U_IMM20  = sel_op.u_imm20;
  assign ALU_IMM12    = sel_op.imm12;
  assign ALU_OPCODE   = sel_op.opcode;
  assign ALU_RS2      = sel_op.rs2;
  assign ALU_FUNCT3   = sel_op.funct3;
  assign ALU_FUNCT1   = sel_op.funct1;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = ALU_OUT;
        rsp_tag_d[i]   = req_tag[i];
      end else if (rsp_valid_q[i] && RSP_READY[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
    op_count_d = op_count_q + {31'd0, |grant};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_valid_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        rsp_data_q[i] <= 32'd0;
        rsp_tag_q[i]  <= '0;
      end
      op_count_q <= 32'd0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      for (int i = 0; i < 2; i++) begin
        rsp_data_q[i] <= rsp_data_d[i];
        rsp_tag_q[i]  <= rsp_tag_d[i];
      end
      op_count_q <= op_count_d;
    end
  end

  assign RSP_VALID = rsp_valid_q;
  assign RSP0_DATA = rsp_data_q[0];
  assign RSP1_DATA = rsp_data_q[1];
  assign RSP0_TAG  = rsp_tag_q[0];
  assign RSP1_TAG  = rsp_tag_q[1];
  assign OP_COUNT  = op_count_q;

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and sequencer that shares one `ALU_32b` between two requesters in the core: the main execute stage (port 0) and the branch/address-generation unit (port 1). It accepts at most one operation per cycle using round-robin priority and drives the shared ALU's operand/decode inputs. It captures `ALU_OUT` into a per-port one-entry response register and returns the result with its tag under valid/ready backpressure.

## Interface
Parameters:
- `TAG_W`, default 4: width of the per-request tag returned with each result.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, asynchronous and active-low.
- `REQ_VALID` in 2: per-port request valid; bit i is port i.
- `REQ_READY` out 2: per-port grant; a transfer occurs when `REQ_VALID[i] & REQ_READY[i]`.
- `REQ0_OP`, `REQ1_OP` in `$bits(alu_req_t)`: packed operation, one per port.
- `REQ0_TAG`, `REQ1_TAG` in `TAG_W`: request tag.
- `RSP_VALID` out 2: per-port result valid.
- `RSP_READY` in 2: per-port result accept.
- `RSP0_DATA`, `RSP1_DATA` out 32: registered result.
- `RSP0_TAG`, `RSP1_TAG` out `TAG_W`: tag of the held result.
- `ALU_RS1_DATA`, `ALU_RS2_DATA`, `ALU_PC` out 32: operand inputs to the shared ALU.
- `ALU_U_IMM20` out 20, `ALU_IMM12` out 12, `ALU_OPCODE` out 7, `ALU_RS2` out 5, `ALU_FUNCT3` out 3, `ALU_FUNCT1` out 1: decode inputs to the shared ALU.
- `ALU_OUT` in 32: combinational result from the shared ALU.
- `OP_COUNT` out 32: count of accepted operations; wraps modulo 2^32.

## Operation
- Each port has a one-entry response slot, either EMPTY or FULL.
- **Eligibility:** port i is eligible when `REQ_VALID[i]` is set and its slot is EMPTY, or FULL and draining this cycle (`RSP_VALID[i] & RSP_READY[i]`).
- **Round-robin grant:**
  - A 1-bit priority pointer `PRIO` names the favoured port.
  - If only one port is eligible, that port is granted.
  - If both are eligible, port `PRIO` is granted.
  - After any grant, `PRIO` becomes the non-granted port. With no grant, `PRIO` holds.
- `REQ_READY` is one-hot or zero and is combinational from `REQ_VALID`, slot state, `RSP_READY` and `PRIO`.
- **ALU drive:** the ALU input ports carry the granted port's `alu_req_t` fields. With no grant they carry port 0's fields; the result is ignored.
- **On an accepted transfer at edge N:**
  - The slot loads `ALU_OUT` and the tag.
  - `RSP_VALID[i]` becomes 1.
  - `OP_COUNT` increments by 1.
- **Slot update:**
  - Drain without refill: the slot returns to EMPTY.
  - Drain and refill in the same cycle: the slot is loaded with the new result and `RSP_VALID` stays 1.
- **Hold:** while `RSP_VALID[i]` is set and `RSP_READY[i]` is low, `RSPi_DATA`/`RSPi_TAG` are held stable.
- **Reset values:**
  - `RSP_VALID` = 0, `RSPi_DATA` = 0, `RSPi_TAG` = 0, `PRIO` = 0, `OP_COUNT` = 0.
  - `REQ_READY` = 0 while `RST_N` is low.
  - Reset mid-operation discards held results without handshake.

## Timing
- Request-to-response latency: exactly 1 cycle. Accept at edge N, `RSP_VALID` high after edge N.
- Aggregate throughput: 1 operation/cycle. Per-port throughput: 1/cycle when uncontested and `RSP_READY` is held high; 1 per 2 cycles each when both ports are continuously eligible.
- Combinational path: `REQ*_OP` -> ALU -> `ALU_OUT` -> slot register. This path sets fmax; the block adds only a 2:1 mux.
- No combinational path from `REQ_VALID` to `RSP_*`.

## Structure
- Package `alu_pkg` holds:
  - `alu_req_t` packed struct: `rs1_data`[31:0], `rs2_data`[31:0], `pc`[31:0], `u_imm20`[19:0], `rs2`[4:0], `imm12`[11:0], `opcode`[6:0], `funct3`[2:0], `funct1`.
  - Opcode constants `OPC_OP` = 7'b0110011 and `OPC_OP_IMM` = 7'b0010011.
- Sub-module `rr_arb2`: inputs eligible[1:0] and a `PRIO` register; outputs grant[1:0]. It contains the only `PRIO` flop.
- `ALU_32b` stays outside the block and is connected at the parent.

## Test plan
- **Single ADD on port 0:** port 0 sends opcode 0110011, funct3 000, funct1 0, rs1 5, rs2 3, tag 2. Required: `REQ_READY` = 01 that cycle; next cycle `RSP_VALID` = 01, `RSP0_DATA` = 8, `RSP0_TAG` = 2; `OP_COUNT` = 1.
- **Contention, both eligible for 4 cycles after reset, `RSP_READY` = 11:**
  - Port 0 sends SUB 10-4; port 1 sends ADD 1+1.
  - Required grant order: 0, 1, 0, 1.
  - Responses: `RSP0_DATA` = 6 and `RSP1_DATA` = 2 alternately.
  - `OP_COUNT` = 4.
- **Backpressure on port 1:** `RSP_READY[1]` = 0 while port 1 keeps requesting. Required:
  - Exactly one result is accepted.
  - `RSP1_DATA`/tag are held stable for 5 cycles.
  - `REQ_READY[1]` = 0 for those 5 cycles.
  - Port 0 is still granted every cycle.
- **Drain and refill:** port 1 slot is FULL with value 7; in one cycle `RSP_READY[1]` = 1 and a new op producing 9 is sent. Required: `REQ_READY[1]` = 1 that cycle, next cycle `RSP1_DATA` = 9, and `RSP_VALID[1]` never drops.
- **Reset mid-operation:** both slots FULL and `OP_COUNT` = 12; assert `RST_N` low asynchronously between edges. Required immediately:
  - `RSP_VALID` = 00, `RSP0_DATA`/`RSP1_DATA` = 0, `RSP0_TAG`/`RSP1_TAG` = 0.
  - `OP_COUNT` = 0, `REQ_READY` = 00.
  - The first grant after release goes to port 0.
- **Counter wrap:** force `OP_COUNT` to 32'hFFFF_FFFF, then accept one op. Required: `OP_COUNT` = 0.
